aes_inv_round_linear: RTL and testbench
=======================================

Name: aes_inv_round_linear

Overview:
- Linear half of one AES decryption round.
- Per-round datapath: InvShiftRows, then AddRoundKey, then InvMixColumns (bypassed on the final round).
- Sits after the external InvSubBytes block in the iterative/unrolled inverse cipher. InvSubBytes and InvShiftRows commute, so the external-first ordering is equivalent to FIPS-197 order.
- 2-stage pipeline with valid/ready flow control.

Parameters:
- DATA_LEN, 128, state and round-key width in bits. Only 128 is supported.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream presents a state.
- ready_out  output  1  block can accept a state this cycle.
- data_in  input  DATA_LEN  state after InvSubBytes.
- key_in  input  DATA_LEN  round key for this state.
- last_in  input  1  final decryption round; bypass InvMixColumns.
- valid_out  output  1  data_out holds a result.
- ready_in  input  1  downstream accepts data_out this cycle.
- data_out  output  DATA_LEN  round output.
- last_out  output  1  last_in carried alongside the result.

Behaviour:
- Byte layout:
  - Byte i = data[127-8i -: 8], i = 0..15.
  - Row = i mod 4, column = i div 4 (column-major, byte 0 = MSB).
  - key_in uses the same layout.
- InvShiftRows: row r rotates right by r. Output column words:
  - c0 = {b0, b13, b10, b7}
  - c1 = {b4, b1, b14, b11}
  - c2 = {b8, b5, b2, b15}
  - c3 = {b12, b9, b6, b3}
- AddRoundKey: 128-bit XOR with key_in, applied after InvShiftRows.
- InvMixColumns: per column, multiply by the circulant matrix with rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
  - GF(2^8) arithmetic, reduction polynomial 0x11B.
  - Implement as an xtime chain; no multipliers, no lookup tables.
- Stage 1 register (s1_data, s1_last, s1_valid) captures InvShiftRows(data_in) XOR key_in.
- Stage 2 register (data_out, last_out, valid_out) captures:
  - s1_last ? s1_data : InvMixColumns(s1_data);
  - valid_out <= s1_valid.
- Flow control:
  - Global enable en = !valid_out || ready_in.
  - ready_out = en (combinational).
  - When en = 1, both stages advance: s1_valid <= valid_in, and stage 2 loads from stage 1.
  - When en = 0, all registers hold. data_out, last_out and valid_out stay stable until accepted.
  - Input transfer occurs on valid_in && ready_out. Output transfer occurs on valid_out && ready_in.
  - A bubble (s1_valid = 0) still advances when en = 1; it is not squeezed.
- Data registers load only when their incoming valid is 1. On a bubble they hold their old contents; only the valid bits clear.
- Latency: 2 cycles from input transfer to valid_out with no stall. Throughput: 1 state per cycle.
- Reset (asynchronous, mid-operation included) clears valid_out, s1_valid, data_out, last_out and s1 data to 0. In-flight states are discarded. ready_out is 1 in the first cycle after release.
- valid_in while ready_out = 0 is not consumed. Upstream must hold data_in, key_in and last_in until transfer.
- No state machine beyond the two valid bits. No X on outputs after reset.

Test Plan:
1. Pure InvShiftRows:
   - Stimulus: data_in = 000102030405060708090a0b0c0d0e0f, key_in = 0, last_in = 1.
   - Required: 2 cycles later data_out = 000d0a07_04010e0b_08050 20f_0c090603 (i.e. 000d0a0704010e0b0805020f0c090603), last_out = 1.
2. InvMixColumns vector:
   - Stimulus: data_in = 8e4da1bc repeated 4 times, key_in = 0, last_in = 0. InvShiftRows is identity here.
   - Required: data_out = db135345 repeated 4 times.
   - Repeat with f20a225c x4 replaced by 9fdc589d x4 in: required data_out = f20a225c x4. Also check c6c6c6c6 x4 and 01010101 x4 map to themselves.
3. Key add:
   - Stimulus: data_in = 0, key_in = 2b7e151628aed2a6abf7158809cf4f3c, last_in = 1.
   - Required: data_out = 2b7e151628aed2a6abf7158809cf4f3c.
   - Same with last_in = 0 and key_in = 01010101 x4: required data_out = 01010101 x4.
4. Streaming and backpressure:
   - Stimulus: 6 back-to-back states with ready_in held 1. Then hold ready_in = 0 for 3 cycles mid-stream.
   - Required with ready_in = 1: outputs appear in order, one per cycle, from cycle 2.
   - Required during the stall: ready_out = 0, data_out/last_out stable, no state lost or duplicated.
   - Scoreboard against a reference model.
5. Bubbles: alternate valid_in 1/0. Required: valid_out pattern mirrors the input pattern delayed by 2 cycles; last_out matches each state.
6. Reset mid-operation:
   - Stimulus: assert reset for one cycle with both stages valid.
   - Required: valid_out = 0 and data_out = 0 immediately (asynchronous); ready_out = 1 after release; next input emerges 2 cycles after its transfer.

Source files
------------

// File: rtl/aes_inv_round_linear.sv
// Linear half of one AES decryption round: InvShiftRows, AddRoundKey, then InvMixColumns
// (skipped on the final round), as a 2-stage valid/ready pipeline with a global stall enable.
module aes_inv_round_linear #(
    parameter int unsigned DATA_LEN = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [DATA_LEN-1:0] data_in,
    input  logic [DATA_LEN-1:0] key_in,
    input  logic                last_in,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [DATA_LEN-1:0] data_out,
    output logic                last_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/b/d/e are assembled from the 1/2/4/8 xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a1 [4];
        logic [7:0] a2 [4];
        logic [7:0] a4 [4];
        logic [7:0] a8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        a1[0] = col[31:24];
        a1[1] = col[23:16];
        a1[2] = col[15:8];
        a1[3] = col[7:0];
        for (int i = 0; i < 4; i++) begin
            a2[i] = xtime(a1[i]);
            a4[i] = xtime(a2[i]);
            a8[i] = xtime(a4[i]);
            m9[i] = a8[i] ^ a1[i];
            mb[i] = a8[i] ^ a2[i] ^ a1[i];
            md[i] = a8[i] ^ a4[i] ^ a1[i];
            me[i] = a8[i] ^ a4[i] ^ a2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic         en;
    logic [7:0]   din_b [16];
    logic [127:0] shifted;
    logic [127:0] s1_next;
    logic [127:0] mixed;

    logic [127:0] s1_data;
    logic         s1_last;
    logic         s1_valid;

    assign en        = !valid_out || ready_in;
    assign ready_out = en;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            din_b[i] = data_in[127-8*i -: 8];
        end
    end

    // Row r rotates right by r; columns are listed MSB first.
    assign shifted = {din_b[0],  din_b[13], din_b[10], din_b[7],
                      din_b[4],  din_b[1],  din_b[14], din_b[11],
                      din_b[8],  din_b[5],  din_b[2],  din_b[15],
                      din_b[12], din_b[9],  din_b[6],  din_b[3]};

    assign s1_next = shifted ^ key_in;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(s1_data[127-32*c -: 32]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_data <= s1_next;
                s1_last <= last_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else if (en) begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                data_out <= s1_last ? s1_data : mixed;
                last_out <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_round_linear.sv
// Scoreboard bench for aes_inv_round_linear: directed vectors, random streaming with stalls,
// bubbles and a mid-operation reset, checked against a byte-level reference model.
module tb_aes_inv_round_linear;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic         ready_out;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         last_in;
    logic         valid_out;
    logic         ready_in;
    logic [127:0] data_out;
    logic         last_out;

    aes_inv_round_linear #(.DATA_LEN(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
        .key_in    (key_in),
        .last_in   (last_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .last_out  (last_out)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        int           cyc;
        logic         chk;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    logic         chk_lat  = 1'b1;
    logic         ovr_en   = 1'b0;
    logic [127:0] ovr_val  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] gmul(input int a, input int b);
        int p;
        int x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p ^= x;
            x = x << 1;
            if ((x & 'h100) != 0) x ^= 'h11b;
        end
        return p[7:0];
    endfunction

    // Reference: matrix form straight from the cipher definition.
    function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                               input logic l);
        int           base [4];
        int           s    [16];
        int           acc;
        logic [7:0]   o    [16];
        logic [127:0] r;
        base[0] = 'h0e; base[1] = 'h0b; base[2] = 'h0d; base[3] = 'h09;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                s[4*c+rr] = int'(d[127-8*(4*((c-rr+4)%4)+rr) -: 8] ^ k[127-8*(4*c+rr) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc ^= int'(gmul(base[(j-rr+4)%4], s[4*c+j]));
                o[4*c+rr] = l ? s[4*c+rr][7:0] : acc[7:0];
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Input-side monitor: push the expected response for every accepted state.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset && valid_in && ready_out) begin
            e.data = ovr_en ? ovr_val : ref_round(data_in, key_in, last_in);
            e.last = last_in;
            e.cyc  = cyc;
            e.chk  = chk_lat;
            q.push_back(e);
        end
    end

    // Output-side monitor.
    initial begin
        logic         prev_vo;
        logic         prev_ri;
        logic [127:0] prev_data;
        logic         prev_last;
        exp_t         e;
        prev_vo = 1'b0;
        prev_ri = 1'b1;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ready_out_rule", 128'(ready_out), 128'(!valid_out || ready_in));
                if (prev_vo && !prev_ri) begin
                    check("stall_valid", 128'(valid_out), 128'(1));
                    check("stall_data", data_out, prev_data);
                    check("stall_last", 128'(last_out), 128'(prev_last));
                    check("stall_ready_out", 128'(ready_out), 128'(ready_in));
                end
                if (valid_out && ready_in) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL spurious_output: got data %h with nothing expected",
                                 data_out);
                    end else begin
                        e = q.pop_front();
                        check("data_out", data_out, e.data);
                        check("last_out", 128'(last_out), 128'(e.last));
                        if (e.chk) check("latency", 128'(cyc - e.cyc), 128'(2));
                    end
                end else if (!valid_out && q.size() > 0 && q[0].chk && cyc >= q[0].cyc + 2) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL missing_output: got valid_out 0 expected 1 at cycle %0d", cyc);
                end
            end
            prev_vo   = valid_out;
            prev_ri   = ready_in;
            prev_data = data_out;
            prev_last = last_out;
        end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l);
        int   n;
        logic acc;
        n = 0;
        valid_in = 1'b1;
        data_in  = d;
        key_in   = k;
        last_in  = l;
        do begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got no transfer expected one within 100 cycles");
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", 128'(q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [127:0] d, input logic [127:0] k, input logic l,
                            input logic [127:0] expv);
        ovr_en  = 1'b1;
        ovr_val = expv;
        send(d, k, l);
        wait_drain();
        ovr_en = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        key_in   = '0;
        last_in  = 1'b0;
        ready_in = 1'b1;
        #12;
        check("reset_valid_out", 128'(valid_out), 128'(0));
        check("reset_data_out", data_out, 128'(0));
        check("reset_last_out", 128'(last_out), 128'(0));
        check("reset_ready_out", 128'(ready_out), 128'(1));
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        directed(128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1,
                 128'h000d0a0704010e0b0805020f0c090603);
        directed({4{32'h8e4da1bc}}, '0, 1'b0, {4{32'hdb135345}});
        directed({4{32'h9fdc589d}}, '0, 1'b0, {4{32'hf20a225c}});
        directed({4{32'hc6c6c6c6}}, '0, 1'b0, {4{32'hc6c6c6c6}});
        directed({4{32'h01010101}}, '0, 1'b0, {4{32'h01010101}});
        directed('0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1,
                 128'h2b7e151628aed2a6abf7158809cf4f3c);
        directed('0, {4{32'h01010101}}, 1'b0, {4{32'h01010101}});

        // Back-to-back stream, no backpressure.
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) send(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
        wait_drain();

        // Stream with a 3-cycle downstream stall in the middle.
        chk_lat = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_in = 1'b1;
            end
            begin
                for (int i = 0; i < 8; i++) send(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
            end
        join
        wait_drain();

        // Bubbles: alternate valid_in 1/0.
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(rnd128(), rnd128(), 1'(i % 2));
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Reset with both stages holding valid states.
        chk_lat = 1'b0;
        send(rnd128(), rnd128(), 1'b0);
        send(rnd128(), rnd128(), 1'b1);
        check("pre_reset_valid_out", 128'(valid_out), 128'(1));
        #1 reset = 1'b0;
        q.delete();
        #1;
        check("async_reset_valid_out", 128'(valid_out), 128'(0));
        check("async_reset_data_out", data_out, 128'(0));
        check("async_reset_last_out", 128'(last_out), 128'(0));
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("post_reset_ready_out", 128'(ready_out), 128'(1));
        check("post_reset_valid_out", 128'(valid_out), 128'(0));
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send(rnd128(), rnd128(), 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
